fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 10'd0, shall be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, shall be the number of consecutive non-ready request cycles tolerated before a fault (range 1..15).
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  begin fetching from IDLE.
REQ-006 HALT  input  1  stop fetching after the current delivery.
REQ-007 STALL  input  1  downstream not ready for the next instruction.
REQ-008 BRANCH_EN  input  1  load PC from BRANCH_ADDR.
REQ-009 BRANCH_ADDR  input  10  branch target word address.
REQ-010 MEM_DATA  input  16  instruction word from program memory.
REQ-011 MEM_READY  input  1  MEM_DATA valid for the current request.
REQ-012 MEM_REQ  output  1  read request to program memory.
REQ-013 MEM_ADDR  output  10  read address, equal to PC at all times.
REQ-014 PC  output  10  program counter.
REQ-015 IR_DATA  output  16  fetched instruction for the instruction register.
REQ-016 IR_EN  output  1  one-cycle load strobe for the instruction register.
REQ-017 FAULT  output  1  sticky memory-timeout flag.

Function
REQ-018 The FSM shall have states IDLE, REQ, DELIVER, HOLD, and ERR.
REQ-019 IDLE: MEM_REQ=0; START=1 -> REQ; otherwise stay.
REQ-020 REQ: MEM_REQ=1; MEM_READY=1 -> capture MEM_DATA into IR_DATA and go to DELIVER; otherwise stay and increment the wait counter.
REQ-021 The wait counter shall clear to 0 on every entry to REQ.
REQ-022 REQ: if MEM_READY=0 and the wait counter equals TIMEOUT-1 -> ERR, so MEM_REQ stays high for exactly TIMEOUT cycles.
REQ-023 DELIVER: IR_EN=1 for exactly one cycle; IR_DATA holds the captured word.
REQ-024 DELIVER next state: HALT=1 -> IDLE; else STALL=1 -> HOLD; else -> REQ.
REQ-025 HOLD: MEM_REQ=0 and IR_EN=0; STALL=0 -> REQ; HALT=1 in HOLD -> IDLE, with HALT having priority over STALL.
REQ-026 PC update on the edge leaving DELIVER: BRANCH_EN=1 -> PC<=BRANCH_ADDR; else PC<=PC+1, modulo 1024 (1023 wraps to 0).
REQ-027 BRANCH_EN in IDLE or HOLD shall load PC<=BRANCH_ADDR without fetching.
REQ-028 BRANCH_EN in REQ or ERR shall be ignored.
REQ-029 BRANCH_EN together with HALT in DELIVER shall load the branch target and go to IDLE.
REQ-030 ERR: MEM_REQ=0, IR_EN=0, FAULT=1; exit only by reset; PC frozen.
REQ-031 IR_DATA shall change only on a REQ capture; it holds its value otherwise.
REQ-032 Latency: START sampled at edge n -> MEM_REQ=1 in cycle n+1. With MEM_READY=1 that cycle -> IR_EN=1 in cycle n+2, and PC=old+1 in cycle n+3.
REQ-033 Back-to-back throughput with zero wait states and no stall shall be one instruction per 2 cycles.
REQ-034 START shall be ignored outside IDLE.

Reset
REQ-035 RESET=0 shall immediately force state=IDLE, PC=RESET_PC, IR_DATA=0, IR_EN=0, MEM_REQ=0, FAULT=0, and wait counter=0.
REQ-036 Reset asserted mid-request shall drop MEM_REQ asynchronously, and any MEM_READY in that cycle shall be discarded.
REQ-037 After release, the block shall remain in IDLE until START=1.

Verification
REQ-038 Reset, then START; memory returns 16'hA5C3 with 0 waits -> MEM_ADDR=0, IR_EN pulse with IR_DATA=16'hA5C3, PC=1, MEM_REQ=1 for addr 1.
REQ-039 MEM_READY delayed 3 cycles -> MEM_REQ high 4 cycles, single IR_EN pulse, FAULT=0.
REQ-040 MEM_READY never asserted with TIMEOUT=15 -> MEM_REQ high exactly 15 cycles, then FAULT=1 sticky, MEM_REQ=0, and ERR persists despite START/BRANCH_EN until RESET.
REQ-041 PC=1023 delivery with no branch -> PC=0 and next MEM_ADDR=0; BRANCH_EN with BRANCH_ADDR=10'h155 in DELIVER -> next MEM_ADDR=10'h155.
REQ-042 STALL=1 for 5 cycles after delivery -> no MEM_REQ and no IR_EN during stall, fetch resumes the cycle after STALL=0; HALT in DELIVER -> IDLE with PC advanced by 1.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Program-memory read bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
  logic        MEM_REQ;
  logic [9:0]  MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic        MEM_READY;

  modport master (output MEM_REQ, output MEM_ADDR, input MEM_DATA, input MEM_READY);
  modport slave  (input MEM_REQ, input MEM_ADDR, output MEM_DATA, output MEM_READY);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests words at PC, strobes them into the IR,
// honours stall/halt/branch and latches a sticky fault on memory timeout.
module fetch_unit #(
  parameter logic [9:0] RESET_PC = 10'd0,
  parameter int         TIMEOUT  = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                HALT,
  input  logic                STALL,
  input  logic                BRANCH_EN,
  input  logic [9:0]          BRANCH_ADDR,
  fetch_unit_if.master        mem_bus,
  output logic [9:0]          PC,
  output logic [15:0]         IR_DATA,
  output logic                IR_EN,
  output logic                FAULT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DELIVER,
    ST_HOLD,
    ST_ERR
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       mem_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    IR_EN      = 1'b0;
    FAULT      = 1'b0;
    unique case (state)
      ST_IDLE: if (START) state_next = ST_REQ;
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_bus.MEM_READY)          state_next = ST_DELIVER;
        else if (wait_cnt == WAIT_LAST) state_next = ST_ERR;
      end
      ST_DELIVER: begin
        IR_EN = 1'b1;
        if (HALT)       state_next = ST_IDLE;
        else if (STALL) state_next = ST_HOLD;
        else            state_next = ST_REQ;
      end
      ST_HOLD: begin
        if (HALT)        state_next = ST_IDLE;
        else if (!STALL) state_next = ST_REQ;
      end
      ST_ERR: FAULT = 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter is held at zero outside REQ, so every entry to REQ starts from 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                                   wait_cnt <= '0;
    else if (state == ST_REQ && !mem_bus.MEM_READY) wait_cnt <= wait_cnt + 4'd1;
    else if (state != ST_REQ)                     wait_cnt <= '0;
  end

  // Branches are honoured only where no request is in flight; REQ and ERR ignore them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PC <= RESET_PC;
    end else begin
      unique case (state)
        ST_IDLE, ST_HOLD: if (BRANCH_EN) PC <= BRANCH_ADDR;
        ST_DELIVER:       PC <= BRANCH_EN ? BRANCH_ADDR : PC + 10'd1;
        default:          PC <= PC;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                                    IR_DATA <= '0;
    else if (state == ST_REQ && mem_bus.MEM_READY) IR_DATA <= mem_bus.MEM_DATA;
  end

  assign mem_bus.MEM_REQ  = mem_req;
  assign mem_bus.MEM_ADDR = PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch latency, wait states, stall/halt,
// branches, PC wrap, asynchronous reset and memory timeout.
module tb_fetch_unit;
  logic        CLK;
  logic        RESET;
  logic        START;
  logic        HALT;
  logic        STALL;
  logic        BRANCH_EN;
  logic [9:0]  BRANCH_ADDR;
  logic [9:0]  PC;
  logic [15:0] IR_DATA;
  logic        IR_EN;
  logic        FAULT;

  int checks = 0;
  int errors = 0;

  fetch_unit_if mem_bus ();

  fetch_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .HALT        (HALT),
    .STALL       (STALL),
    .BRANCH_EN   (BRANCH_EN),
    .BRANCH_ADDR (BRANCH_ADDR),
    .mem_bus     (mem_bus.master),
    .PC          (PC),
    .IR_DATA     (IR_DATA),
    .IR_EN       (IR_EN),
    .FAULT       (FAULT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int req_cycles;
    logic quiet;

    RESET = 1'b0; START = 1'b0; HALT = 1'b0; STALL = 1'b0;
    BRANCH_EN = 1'b0; BRANCH_ADDR = '0;
    mem_bus.MEM_DATA = '0; mem_bus.MEM_READY = 1'b0;
    #3;
    check("rst_pc",      32'(PC), 32'h0);
    check("rst_req",     32'(mem_bus.MEM_REQ), 32'h0);
    check("rst_ir_en",   32'(IR_EN), 32'h0);
    check("rst_fault",   32'(FAULT), 32'h0);
    check("rst_ir_data", 32'(IR_DATA), 32'h0);
    tick(); tick();
    RESET = 1'b1;
    tick(); tick();
    check("idle_no_req", 32'(mem_bus.MEM_REQ), 32'h0);

    // Zero-wait fetch of 16'hA5C3 from address 0
    START = 1'b1; mem_bus.MEM_READY = 1'b1; mem_bus.MEM_DATA = 16'hA5C3;
    tick();
    START = 1'b0;
    check("f0_req",  32'(mem_bus.MEM_REQ), 32'h1);
    check("f0_addr", 32'(mem_bus.MEM_ADDR), 32'h0);
    tick();
    mem_bus.MEM_READY = 1'b0; mem_bus.MEM_DATA = 16'h1111;
    check("f0_ir_en",  32'(IR_EN), 32'h1);
    check("f0_ir",     32'(IR_DATA), 32'hA5C3);
    check("f0_no_req", 32'(mem_bus.MEM_REQ), 32'h0);
    tick();
    check("f1_pc",    32'(PC), 32'h1);
    check("f1_req",   32'(mem_bus.MEM_REQ), 32'h1);
    check("f1_addr",  32'(mem_bus.MEM_ADDR), 32'h1);
    check("f1_ir_en", 32'(IR_EN), 32'h0);

    // Three wait states: request stays up for cycles 2..4, ready in cycle 4
    tick(); check("w_req_c2", 32'(mem_bus.MEM_REQ), 32'h1);
    tick(); check("w_req_c3", 32'(mem_bus.MEM_REQ), 32'h1);
    tick(); check("w_req_c4", 32'(mem_bus.MEM_REQ), 32'h1);
    mem_bus.MEM_READY = 1'b1; mem_bus.MEM_DATA = 16'hBEEF;
    tick();
    mem_bus.MEM_READY = 1'b0; STALL = 1'b1;
    check("w_ir_en", 32'(IR_EN), 32'h1);
    check("w_ir",    32'(IR_DATA), 32'hBEEF);
    check("w_fault", 32'(FAULT), 32'h0);
    check("w_pc",    32'(PC), 32'h1);

    // Stall for 5 cycles after delivery, then resume
    tick();
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (mem_bus.MEM_REQ || IR_EN) quiet = 1'b0;
      if (i == 4) STALL = 1'b0;
      tick();
    end
    check("stall_quiet", 32'(quiet), 32'h1);
    check("resume_req",  32'(mem_bus.MEM_REQ), 32'h1);
    check("resume_addr", 32'(mem_bus.MEM_ADDR), 32'h2);

    // Halt in DELIVER returns to IDLE with PC advanced
    mem_bus.MEM_READY = 1'b1; mem_bus.MEM_DATA = 16'h1234;
    tick();
    mem_bus.MEM_READY = 1'b0; HALT = 1'b1;
    tick();
    HALT = 1'b0;
    check("halt_req", 32'(mem_bus.MEM_REQ), 32'h0);
    check("halt_pc",  32'(PC), 32'h3);
    tick();
    check("halt_idle", 32'(mem_bus.MEM_REQ), 32'h0);

    // Branch in IDLE loads PC without fetching; IR_DATA holds
    BRANCH_EN = 1'b1; BRANCH_ADDR = 10'h3FF;
    tick();
    BRANCH_EN = 1'b0;
    check("ibr_pc",  32'(PC), 32'h3FF);
    check("ibr_req", 32'(mem_bus.MEM_REQ), 32'h0);
    check("ibr_ir",  32'(IR_DATA), 32'h1234);

    // Fetch at 1023 wraps to 0, then a branch in DELIVER redirects to 0x155
    START = 1'b1; mem_bus.MEM_READY = 1'b1; mem_bus.MEM_DATA = 16'hCAFE;
    tick();
    START = 1'b0;
    check("wrap_addr", 32'(mem_bus.MEM_ADDR), 32'h3FF);
    tick();
    mem_bus.MEM_READY = 1'b0;
    tick();
    check("wrap_pc",   32'(PC), 32'h0);
    check("wrap_next", 32'(mem_bus.MEM_ADDR), 32'h0);
    mem_bus.MEM_READY = 1'b1;
    tick();
    mem_bus.MEM_READY = 1'b0; BRANCH_EN = 1'b1; BRANCH_ADDR = 10'h155;
    tick();
    check("dbr_addr", 32'(mem_bus.MEM_ADDR), 32'h155);
    check("dbr_req",  32'(mem_bus.MEM_REQ), 32'h1);
    BRANCH_ADDR = 10'h0AA;
    tick();
    BRANCH_EN = 1'b0;
    check("rbr_ignored", 32'(mem_bus.MEM_ADDR), 32'h155);

    // Reset mid-request drops MEM_REQ at once and discards the ready word
    mem_bus.MEM_READY = 1'b1; mem_bus.MEM_DATA = 16'hDEAD;
    #1 RESET = 1'b0;
    #1;
    check("arst_req", 32'(mem_bus.MEM_REQ), 32'h0);
    check("arst_pc",  32'(PC), 32'h0);
    tick();
    check("arst_ir",    32'(IR_DATA), 32'h0);
    check("arst_ir_en", 32'(IR_EN), 32'h0);
    RESET = 1'b1; mem_bus.MEM_READY = 1'b0;
    tick(); tick();
    check("arst_idle", 32'(mem_bus.MEM_REQ), 32'h0);

    // Memory never ready: 15 request cycles, then sticky fault
    START = 1'b1;
    tick();
    START = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.MEM_REQ) req_cycles++;
      tick();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd15);
    check("to_fault",      32'(FAULT), 32'h1);
    check("to_req_low",    32'(mem_bus.MEM_REQ), 32'h0);
    START = 1'b1; BRANCH_EN = 1'b1; BRANCH_ADDR = 10'h2AA;
    tick(); tick(); tick();
    START = 1'b0; BRANCH_EN = 1'b0;
    check("err_fault", 32'(FAULT), 32'h1);
    check("err_req",   32'(mem_bus.MEM_REQ), 32'h0);
    check("err_pc",    32'(PC), 32'h0);
    RESET = 1'b0;
    #1;
    check("err_clear", 32'(FAULT), 32'h0);
    RESET = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
